// File: rtl/data_mem_ctrl.sv
// MIPS32 byte/half/word data memory behind a req/ready handshake, WAIT_STATES extra cycles per access.
// Optional DMEM_OOR_CHECK_EN: word indices >= DEPTH are rejected instead of wrapping.
module data_mem_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic        we_q, sign_ext_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [31:0]   word, ld_val, st_word, wd_lanes;
  logic [3:0]    be;
  logic [7:0]    b;
  logic [15:0]   h;
  logic          misalign, oor, err_c;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    busy      = (state == WAIT) || (state == ACCESS);
    ready     = (state == DONE);
    case (state)
      IDLE, DONE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt = ACCESS;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WS_INIT;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = ACCESS;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ACCESS:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sign_ext_q <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q       <= we;
        size_q     <= size;
        sign_ext_q <= sign_ext;
        addr_q     <= addr;
        wdata_q    <= wdata;
      end
    end
  end

  assign idx  = addr_q[AW+1:2];
  assign word = mem[idx];
  assign b    = word[{addr_q[1:0], 3'b000} +: 8];
  assign h    = addr_q[1] ? word[31:16] : word[15:0];

  assign misalign = (size_q == 2'b11) ||
                    ((size_q == 2'b01) && addr_q[0]) ||
                    ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`ifdef DMEM_OOR_CHECK_EN
  assign oor = |addr_q[31:AW+2];
`else
  logic unused_addr_hi;
  assign oor            = 1'b0;
  assign unused_addr_hi = ^addr_q[31:AW+2];
`endif
  assign err_c = misalign || oor;

  // Store data is replicated across lanes so the byte enables alone select what lands.
  always_comb begin
    wd_lanes = wdata_q;
    be       = 4'b1111;
    case (size_q)
      2'b00: begin
        wd_lanes = {4{wdata_q[7:0]}};
        be       = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        wd_lanes = {2{wdata_q[15:0]}};
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    st_word = word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) st_word[8*i +: 8] = wd_lanes[8*i +: 8];
    end
  end

  always_comb begin
    ld_val = word;
    case (size_q)
      2'b00:   ld_val = {{24{sign_ext_q & b[7]}}, b};
      2'b01:   ld_val = {{16{sign_ext_q & h[15]}}, h};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= 32'd0;
      err   <= 1'b0;
    end else if (state == ACCESS) begin
      err   <= err_c;
      rdata <= (err_c || we_q) ? 32'd0 : ld_val;
    end
  end

  // Storage is deliberately not reset; async reset moves state out of ACCESS so no write follows.
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q && !err_c) mem[idx] <= st_word;
  end
endmodule
